// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Handshake: imem_req is held with a stable imem_addr until a cycle with imem_ack=1; imem_rdata is valid only in that cycle.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS PC/fetch stage: IDLE -> FETCH -> EXEC loop, next PC = jump > branch > PC+4.
// Optional fetch watchdog and ERR state enabled by defining FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic [31:0]            imm_ext,
  input  logic [25:0]            jump_index,
  output logic                   fetch_err,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] ST_ERR   = 2'd3;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_imm_sh;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_imm_sh   = imm_ext << 2;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      w_next_pc = w_pc_plus4 + w_imm_sh;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Counts completed no-ack FETCH cycles; zero whenever FETCH is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != ST_FETCH) begin
      r_cnt <= '0;
    end else if (!imem.imem_ack) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ack) begin
          w_state_nxt = ST_EXEC;
`ifdef FETCH_TIMEOUT_EN
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_ERR;
`endif
        end
      end
      ST_EXEC:  if (!stall) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && imem.imem_ack) begin
        r_instr <= imem.imem_rdata;
      end
      // PC only moves as EXEC hands back to FETCH; control inputs are sampled here alone.
      if (r_state == ST_EXEC && !stall) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign imem.imem_req  = (r_state == ST_FETCH);
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = (r_state == ST_EXEC);
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign dbg_state      = r_state;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err      = (r_state == ST_ERR);
`else
  assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: memory responder, PC model and fetch-address/instruction scoreboard.
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC       = 32'h0040_0000;
  localparam int          TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [25:0] jump_index = '0;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  fetch_pc_unit_if imem_bus ();

  fetch_pc_unit #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .imm_ext      (imm_ext),
    .jump_index   (jump_index),
    .fetch_err    (fetch_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a request, checks its address against the queue, then acks after 'waits' cycles.
  task automatic serve_fetch(input int waits, input logic [31:0] data);
    int          guard;
    logic [31:0] exp_addr;
    logic [31:0] addr0;
    guard = 0;
    while (!imem_bus.imem_req && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (imem_bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_req_wait: imem_req=%b after %0d cycles, required 1", imem_bus.imem_req, guard);
      return;
    end
    exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
    n_checks++;
    if (imem_bus.imem_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h, required %h", imem_bus.imem_addr, exp_addr);
    end
    addr0 = imem_bus.imem_addr;
    for (int w = 0; w < waits; w++) begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr0 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_hold: req=%b addr=%h err=%b, required req=1 addr=%h err=0",
                 imem_bus.imem_req, imem_bus.imem_addr, fetch_err, addr0);
      end
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    instr_q.push_back(data);
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
  endtask

  // Checks the EXEC state, optionally stalls (with ignored acks), then releases with the given controls.
  task automatic exec_step(input int n_stall, input logic br, input logic jp,
                           input logic [31:0] imm, input logic [25:0] jidx);
    logic [31:0] exp_instr;
    logic [31:0] p4;
    logic [31:0] nxt;
    exp_instr = (instr_q.size() > 0) ? instr_q.pop_front() : 32'hxxxx_xxxx;
    n_checks++;
    if (instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_flags: valid=%b req=%b err=%b, required 1 0 0", instr_valid, imem_bus.imem_req, fetch_err);
    end
    n_checks++;
    if (instr !== exp_instr) begin
      n_fail++;
      $display("FAIL exec_instr: got %h, required %h", instr, exp_instr);
    end
    n_checks++;
    if (pc !== model_pc || pc_plus4 !== model_pc + 32'd4) begin
      n_fail++;
      $display("FAIL exec_pc: pc=%h pc_plus4=%h, required %h %h", pc, pc_plus4, model_pc, model_pc + 32'd4);
    end
    for (int s = 0; s < n_stall; s++) begin
      stall               = 1'b1;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== model_pc || instr !== exp_instr) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b req=%b pc=%h instr=%h, required 1 0 %h %h",
                 instr_valid, imem_bus.imem_req, pc, instr, model_pc, exp_instr);
      end
    end
    imem_bus.imem_ack = 1'b0;
    stall        = 1'b0;
    branch_taken = br;
    jump         = jp;
    imm_ext      = imm;
    jump_index   = jidx;
    p4 = model_pc + 32'd4;
    if (jp)      nxt = {p4[31:28], jidx, 2'b00};
    else if (br) nxt = p4 + {imm[29:0], 2'b00};
    else         nxt = p4;
    addr_q.push_back(nxt);
    model_pc = nxt;
    @(negedge clk);
    branch_taken = 1'($urandom);
    jump         = 1'($urandom);
    imm_ext      = $urandom;
    jump_index   = 26'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    addr_q.delete();
    instr_q.delete();
    model_pc = RESET_PC;
    addr_q.push_back(RESET_PC);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 ||
          pc !== RESET_PC || instr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_values: req=%b valid=%b err=%b pc=%h instr=%h, required 0 0 0 %h 0",
                 imem_bus.imem_req, instr_valid, fetch_err, pc, instr, RESET_PC);
      end
    end
    addr_q.delete();
    instr_q.delete();
    model_pc = RESET_PC;
    addr_q.push_back(RESET_PC);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_bus.imem_req !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_state: req=%b state=%0d, required 0 0", imem_bus.imem_req, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC);
    end
    serve_fetch(0, 32'h2008_0005);
    exec_step(0, 1'b0, 1'b0, 32'h0, 26'h0);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      serve_fetch(0, $urandom);
      exec_step(0, 1'b0, 1'b0, $urandom, 26'($urandom));
    end
  endtask

  task automatic test_branch();
    serve_fetch(0, 32'h1000_FFFE);
    exec_step(0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
    serve_fetch(1, 32'h1000_0004);
    exec_step(0, 1'b1, 1'b0, 32'h0000_0004, 26'h0);
  endtask

  task automatic test_jump();
    serve_fetch(0, 32'h0810_0040);
    exec_step(0, 1'b1, 1'b1, 32'h0000_0010, 26'h010_0040);
  endtask

  task automatic test_stall();
    serve_fetch(0, 32'h0000_0020);
    exec_step(3, 1'b0, 1'b0, 32'h0, 26'h0);
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_instr;
    serve_fetch(3, 32'h2108_0001);
    exp_instr = instr_q.pop_front();
    n_checks++;
    if (instr !== exp_instr || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_instr: instr=%h valid=%b, required %h 1", instr, instr_valid, exp_instr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || pc !== RESET_PC || instr !== 32'h0 || imem_bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_exec_reset: valid=%b pc=%h instr=%h req=%b, required 0 %h 0 0",
               instr_valid, pc, instr, imem_bus.imem_req, RESET_PC);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    serve_fetch(0, $urandom);
    exec_step(0, 1'b1, 1'b0, 32'hFFEF_FFFE, 26'h0);
    serve_fetch(0, $urandom);
    exec_step(0, 1'b0, 1'b0, 32'h0, 26'h0);
    serve_fetch(0, $urandom);
    exec_step(0, 1'b0, 1'b1, 32'h0, 26'h3FF_FFFF);
    serve_fetch(2, $urandom);
    exec_step(0, 1'b0, 1'b0, 32'h0, 26'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      serve_fetch($urandom_range(0, 2), $urandom);
      exec_step($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, 26'($urandom));
    end
  endtask

  task automatic test_timeout();
    int          guard;
    logic [31:0] exp_addr;
    do_reset();
    serve_fetch(TIMEOUT_CYCLES - 1, 32'h3C01_1234);
    exec_step(0, 1'b0, 1'b0, 32'h0, 26'h0);
    guard = 0;
    while (!imem_bus.imem_req && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    exp_addr = addr_q.pop_front();
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL stuck_fetch_start: req=%b addr=%h, required 1 %h", imem_bus.imem_req, imem_bus.imem_addr, exp_addr);
    end
`ifdef FETCH_TIMEOUT_EN
    for (int c = 1; c < TIMEOUT_CYCLES; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_bus.imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_timeout: cycle %0d req=%b err=%b, required 1 0", c + 1, imem_bus.imem_req, fetch_err);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_err !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_err: err=%b req=%b valid=%b, required 1 0 0", fetch_err, imem_bus.imem_req, instr_valid);
      end
    end
`else
    for (int c = 0; c < TIMEOUT_CYCLES + 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_bus.imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_bus.imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL no_timeout: req=%b err=%b addr=%h, required 1 0 %h",
                 imem_bus.imem_req, fetch_err, imem_bus.imem_addr, exp_addr);
      end
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wait_states();
    test_wrap();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the MIPS datapath. Holds the PC, requests instructions from instruction memory with a req/ack handshake, and presents each fetched word to decode. It consumes the 32-bit sign-extended immediate and the 26-bit jump index to form the next PC (PC+4, branch target, or jump target). It sits directly downstream of the immediate sign-extension stage on the branch-target path.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 16, FETCH cycles without ack before error (used only with FETCH_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr  out  32  registered instruction for decode
- instr_valid  out  1  instr valid, decode/execute may proceed
- pc  out  32  PC of the current instruction
- pc_plus4  out  32  pc + 4
- stall  in  1  hold current instruction, do not advance
- branch_taken  in  1  branch condition (branch & zero) for the current instruction
- jump  in  1  current instruction is J-type
- imm_ext  in  32  sign-extended 16-bit immediate
- jump_index  in  26  instr[25:0] jump field
- fetch_err  out  1  sticky fetch-timeout flag

## Operation
- FSM states: IDLE, FETCH, EXEC, ERR.
- IDLE: entered on reset. Lasts exactly one cycle after rst_n deasserts, then moves to FETCH.
- FETCH:
  - imem_req=1; imem_addr=pc, stable for the whole state.
  - On imem_ack=1: instr <= imem_rdata, then go to EXEC.
  - imem_ack outside FETCH is ignored.
- EXEC: instr_valid=1.
  - If stall=1: remain in EXEC; pc and instr hold.
  - If stall=0: pc <= next_pc, then go to FETCH.
- next_pc priority: jump > branch_taken > sequential.
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - Branch: pc_plus4 + (imm_ext << 2).
  - Sequential: pc_plus4.
- Arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0. Negative imm_ext wraps correctly.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0.
- Reset asserted mid-operation forces the reset values immediately and discards any outstanding fetch.

## Timing
- Zero-wait memory (ack in first FETCH cycle) gives 2 cycles per instruction: FETCH then EXEC.
- Each wait state adds one FETCH cycle.
- imem_req, instr_valid and fetch_err decode from the registered state and carry no combinational input paths.
- imem_addr is driven from the pc register.
- pc changes only at the EXEC→FETCH edge.
- branch_taken, jump, imm_ext and jump_index are sampled only on that edge.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without ack.
  - If ack is absent for TIMEOUT_CYCLES consecutive FETCH cycles, the FSM enters ERR at the end of the last one.
  - An ack in that last cycle is accepted and takes priority.
  - ERR: imem_req=0, fetch_err=1, instr_valid=0. Held until reset.
- FETCH_TIMEOUT_EN undefined:
  - No counter and no ERR state.
  - FETCH waits indefinitely; fetch_err is tied to 0.

## Test plan
- Reset, RESET_PC=32'h0040_0000, zero-wait memory:
  - imem_req=0 during reset and in IDLE.
  - imem_req=1 with addr 0x0040_0000 in cycle 1.
  - instr_valid=1 in cycle 2.
  - Next fetch addr 0x0040_0004.
- Branch: pc=0x0040_0010, branch_taken=1, imm_ext=32'hFFFF_FFFE → next fetch addr 0x0040_000C.
- Jump overrides branch: pc=0x0040_0020, jump=1, branch_taken=1, jump_index=26'h010_0040 → next fetch addr 0x0040_0100.
- Stall:
  - stall=1 for 3 EXEC cycles → instr_valid held, pc and instr unchanged, imem_req=0.
  - stall drops → fetch at pc+4.
- Wait states:
  - ack after 3 FETCH cycles, imem_rdata=0x2108_0001 only on the ack cycle → imem_addr stable throughout; instr=0x2108_0001.
  - rst_n pulsed low mid-EXEC → instr_valid=0 and pc=RESET_PC immediately.
- Timeout, TIMEOUT_CYCLES=16:
  - Macro defined, no ack → fetch_err=1 and imem_req=0 after the 16th FETCH cycle.
  - Ack on the 16th cycle → no error.
  - Macro undefined → imem_req stays 1 and fetch_err=0.
